// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencer for the MIPS pipeline: PC / IF/ID enables, NOP injection and IF/ID flush.
// Handles load-use bubbles, redirects, data-memory busy freezes and halt, with a saturating stall counter.
module fetch_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs_in,
   input  logic [4:0]       id_rt_in,
   input  logic             id_uses_rt_in,
   input  logic [4:0]       ex_dest_in,
   input  logic             ex_mem_re_in,
   input  logic             redirect_in,
   input  logic             mem_busy_in,
   input  logic             halt_in,
   output logic             pc_en_out,
   output logic             ifid_en_out,
   output logic             nop_sel_out,
   output logic             flush_out,
   output logic             halted_out,
   output logic [CNT_W-1:0] stall_count_out,
   output logic [1:0]       state_out
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      HALT       = 2'd3
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t           state;
   state_t           next_state;
   logic [2:0]       flush_cnt;
   logic [2:0]       next_flush_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             hz;

   // Register zero is never a real dependency, so a load targeting $0 causes no bubble.
   assign hz = ex_mem_re_in & (ex_dest_in != 5'd0) &
               ((ex_dest_in == id_rs_in) | (id_uses_rt_in & (ex_dest_in == id_rt_in)));

   always_comb begin
      pc_en_out      = 1'b1;
      ifid_en_out    = 1'b1;
      nop_sel_out    = 1'b0;
      flush_out      = 1'b0;
      halted_out     = 1'b0;
      next_state     = state;
      next_flush_cnt = flush_cnt;
      if (reset) begin
         pc_en_out   = 1'b0;
         ifid_en_out = 1'b0;
         nop_sel_out = 1'b1;
         flush_out   = 1'b1;
      end else if (state == HALT) begin
         pc_en_out   = 1'b0;
         ifid_en_out = 1'b0;
         nop_sel_out = 1'b1;
         halted_out  = 1'b1;
      end else if (mem_busy_in) begin
         pc_en_out   = 1'b0;
         ifid_en_out = 1'b0;
      end else if (redirect_in) begin
         nop_sel_out = 1'b1;
         flush_out   = 1'b1;
         if (FLUSH_CYCLES == 1) begin
            next_state = RUN;
         end else begin
            next_state     = FLUSH;
            next_flush_cnt = FLUSH_INIT;
         end
      end else if (state == FLUSH) begin
         // ID holds wrong-path instructions here, so halt and hazards are ignored.
         nop_sel_out    = 1'b1;
         flush_out      = 1'b1;
         next_flush_cnt = flush_cnt - 3'd1;
         if (flush_cnt == 3'd1) begin
            next_state = RUN;
         end
      end else if (halt_in) begin
         pc_en_out   = 1'b0;
         ifid_en_out = 1'b0;
         nop_sel_out = 1'b1;
         next_state  = HALT;
      end else if ((state == RUN) && hz) begin
         pc_en_out   = 1'b0;
         ifid_en_out = 1'b0;
         nop_sel_out = 1'b1;
         next_state  = LOAD_STALL;
      end else begin
         next_state = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
         stall_cnt <= '0;
      end else begin
         state     <= next_state;
         flush_cnt <= next_flush_cnt;
         if (!pc_en_out && (state != HALT) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign stall_count_out = stall_cnt;
   assign state_out       = state;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl with FLUSH_CYCLES=3 and CNT_W=4.
// Inputs change on the falling edge; combinational outputs are checked 1 ns later.
module tb_fetch_hazard_ctrl;

   localparam int CNT_W = 4;

   // Output patterns {pc_en, ifid_en, nop_sel, flush, halted}
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b00100;
   localparam logic [4:0] O_FLUSH = 5'b11110;
   localparam logic [4:0] O_BUSY  = 5'b00000;
   localparam logic [4:0] O_HALT  = 5'b00101;
   localparam logic [4:0] O_RST   = 5'b00110;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs_in;
   logic [4:0]       id_rt_in;
   logic             id_uses_rt_in;
   logic [4:0]       ex_dest_in;
   logic             ex_mem_re_in;
   logic             redirect_in;
   logic             mem_busy_in;
   logic             halt_in;
   logic             pc_en_out;
   logic             ifid_en_out;
   logic             nop_sel_out;
   logic             flush_out;
   logic             halted_out;
   logic [CNT_W-1:0] stall_count_out;
   logic [1:0]       state_out;

   int n_assert = 0;
   int n_fail   = 0;

   fetch_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs_in        (id_rs_in),
      .id_rt_in        (id_rt_in),
      .id_uses_rt_in   (id_uses_rt_in),
      .ex_dest_in      (ex_dest_in),
      .ex_mem_re_in    (ex_mem_re_in),
      .redirect_in     (redirect_in),
      .mem_busy_in     (mem_busy_in),
      .halt_in         (halt_in),
      .pc_en_out       (pc_en_out),
      .ifid_en_out     (ifid_en_out),
      .nop_sel_out     (nop_sel_out),
      .flush_out       (flush_out),
      .halted_out      (halted_out),
      .stall_count_out (stall_count_out),
      .state_out       (state_out)
   );

   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic [4:0] dest, input logic re,
                                 input logic redir, input logic busy, input logic halt);
      @(negedge clk);
      reset         = rst;
      id_rs_in      = rs;
      id_rt_in      = rt;
      id_uses_rt_in = uses_rt;
      ex_dest_in    = dest;
      ex_mem_re_in  = re;
      redirect_in   = redir;
      mem_busy_in   = busy;
      halt_in       = halt;
      #1;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_output(input string tag, input logic [4:0] exp_o,
                               input logic [1:0] exp_state, input logic [CNT_W-1:0] exp_stall);
      logic [6:0] obs;
      logic [6:0] exp;
      obs = {pc_en_out, ifid_en_out, nop_sel_out, flush_out, halted_out, state_out};
      exp = {exp_o, exp_state};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s outs{pc,ifid,nop,flush,halted,state} observed=%b expected=%b", tag, obs, exp);
      end
      n_assert++;
      assert (stall_count_out === exp_stall) else begin
         n_fail++;
         $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count_out, exp_stall);
      end
   endtask

   initial begin
      reset = 1'b1;
      id_rs_in = '0; id_rt_in = '0; id_uses_rt_in = 1'b0; ex_dest_in = '0;
      ex_mem_re_in = 1'b0; redirect_in = 1'b0; mem_busy_in = 1'b0; halt_in = 1'b0;

      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("reset", O_RST, 2'd0, 4'd0);
      idle();
      check_output("run_idle", O_RUN, 2'd0, 4'd0);

      // Load-use via rs and via rt
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("lu_rs_detect", O_STALL, 2'd0, 4'd0);
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("lu_rs_one_bubble", O_RUN, 2'd1, 4'd1);
      idle();
      check_output("lu_rs_back_run", O_RUN, 2'd0, 4'd1);
      apply_stimulus(1'b0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("lu_rt_detect", O_STALL, 2'd0, 4'd1);
      idle();
      check_output("lu_rt_bubble", O_RUN, 2'd1, 4'd2);
      apply_stimulus(1'b0, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("rt_unused", O_RUN, 2'd0, 4'd2);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("reg_zero", O_RUN, 2'd0, 4'd2);
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("not_load", O_RUN, 2'd0, 4'd2);

      // Redirect with three flush cycles
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("redir_cycle", O_FLUSH, 2'd0, 4'd2);
      idle();
      check_output("flush_1", O_FLUSH, 2'd2, 4'd2);
      idle();
      check_output("flush_2", O_FLUSH, 2'd2, 4'd2);
      idle();
      check_output("flush_done", O_RUN, 2'd0, 4'd2);

      // Inside FLUSH: halt/hz ignored, redirect restarts, busy holds the count
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("redir2", O_FLUSH, 2'd0, 4'd2);
      apply_stimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      check_output("flush_ignores_halt_hz", O_FLUSH, 2'd2, 4'd2);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("redir_in_flush", O_FLUSH, 2'd2, 4'd2);
      idle();
      check_output("flush_restarted", O_FLUSH, 2'd2, 4'd2);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("busy_in_flush", O_BUSY, 2'd2, 4'd2);
      idle();
      check_output("flush_after_busy", O_FLUSH, 2'd2, 4'd3);
      idle();
      check_output("flush_exit", O_RUN, 2'd0, 4'd3);

      // Mid-operation reset, then busy over a pending hazard
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("reset_mid", O_RST, 2'd0, 4'd3);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
         check_output($sformatf("busy_hz_%0d", i), O_BUSY, 2'd0, 4'(i));
      end
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("hz_after_busy", O_STALL, 2'd0, 4'd4);
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("bubble_after_busy", O_RUN, 2'd1, 4'd5);
      idle();
      check_output("run_after_busy", O_RUN, 2'd0, 4'd5);

      // Redirect beats halt and hazard
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
      check_output("redir_halt_hz", O_FLUSH, 2'd0, 4'd5);
      idle();
      check_output("rhh_flush_1", O_FLUSH, 2'd2, 4'd5);
      idle();
      check_output("rhh_flush_2", O_FLUSH, 2'd2, 4'd5);

      // Halt detected in LOAD_STALL, then HALT ignores everything
      apply_stimulus(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("hz_before_halt", O_STALL, 2'd0, 4'd5);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("halt_detect", O_STALL, 2'd1, 4'd6);
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, (i % 3) == 0, (i % 3) == 1, 1'b1);
         check_output($sformatf("halted_%0d", i), O_HALT, 2'd3, 4'd7);
      end
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("reset_in_halt", O_RST, 2'd3, 4'd7);
      idle();
      check_output("after_halt_reset", O_RUN, 2'd0, 4'd0);

      // Twenty load-use hazards saturate the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
         check_output($sformatf("sat_hz_%0d", i), O_STALL, 2'd0, (i < 15) ? 4'(i) : 4'd15);
         idle();
         check_output($sformatf("sat_idle_%0d", i), O_RUN, 2'd1, (i < 14) ? 4'(i + 1) : 4'd15);
      end
      idle();
      check_output("sat_hold", O_RUN, 2'd0, 4'd15);

      // Busy while in LOAD_STALL holds the state
      apply_stimulus(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("ls_enter", O_STALL, 2'd0, 4'd15);
      apply_stimulus(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      check_output("busy_in_ls", O_BUSY, 2'd1, 4'd15);
      apply_stimulus(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("ls_after_busy", O_RUN, 2'd1, 4'd15);
      idle();
      check_output("final_run", O_RUN, 2'd0, 4'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
